wb_addr_mux_2: RTL and testbench

- Wishbone classic address decoder/multiplexer: one master port to two slave ports.
- Each cycle is routed to the slave whose address window (base, mask) matches the master address.
- Slave responses are multiplexed back to the master.
- Sits between a bus master (CPU or DMA) and two peripherals or memories.
- Purely combinational datapath; zero-cycle latency.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_addr_match.sv | 29 ++
 rtl/wb_addr_mux_2.sv | 109 ++++++++++
 tb/tb_wb_addr_mux_2.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone defaults and the address-window match helper.
// Used by the address decoder and the two-slave multiplexer.
package wb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int MAX_ADDR_WIDTH = 64;

  // A window matches when every masked bit of addr equals base.
  function automatic logic addr_match(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input logic [MAX_ADDR_WIDTH-1:0] base,
    input logic [MAX_ADDR_WIDTH-1:0] mask
  );
    return ~|((addr ^ base) & mask);
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Single address-window comparator for the Wishbone decoder.
// A zero mask matches every address.
module wb_addr_match
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] mask,
  output logic                  match
);

  logic [MAX_ADDR_WIDTH-1:0] adr_x;
  logic [MAX_ADDR_WIDTH-1:0] base_x;
  logic [MAX_ADDR_WIDTH-1:0] mask_x;

  always_comb begin
    adr_x  = '0;
    base_x = '0;
    mask_x = '0;
    adr_x[ADDR_WIDTH-1:0]  = adr;
    base_x[ADDR_WIDTH-1:0] = base;
    mask_x[ADDR_WIDTH-1:0] = mask;
  end

  assign match = addr_match(adr_x, base_x, mask_x);

endmodule

// File: rtl/wb_addr_mux_2.sv
// Wishbone classic decoder/mux: one master to two slave windows.
// Fully combinational; slave 0 wins overlapping windows.
module wb_addr_mux_2
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
  output logic                    wbs0_we_o,
  output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
  output logic                    wbs0_stb_o,
  input  logic                    wbs0_ack_i,
  input  logic                    wbs0_err_i,
  input  logic                    wbs0_rty_i,
  output logic                    wbs0_cyc_o,
  input  logic [ADDR_WIDTH-1:0]   wbs0_addr,
  input  logic [ADDR_WIDTH-1:0]   wbs0_addr_msk,
  output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
  output logic                    wbs1_we_o,
  output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
  output logic                    wbs1_stb_o,
  input  logic                    wbs1_ack_i,
  input  logic                    wbs1_err_i,
  input  logic                    wbs1_rty_i,
  output logic                    wbs1_cyc_o,
  input  logic [ADDR_WIDTH-1:0]   wbs1_addr,
  input  logic [ADDR_WIDTH-1:0]   wbs1_addr_msk
);

  // No state lives here; the clock is part of the bus bundle only.
  logic unused_clk;
  assign unused_clk = clk;

  logic match0;
  logic match1;
  logic sel0;
  logic sel1;
  logic decode_err;

  wb_addr_match #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_match0 (
    .adr   (wbm_adr_i),
    .base  (wbs0_addr),
    .mask  (wbs0_addr_msk),
    .match (match0)
  );

  wb_addr_match #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_match1 (
    .adr   (wbm_adr_i),
    .base  (wbs1_addr),
    .mask  (wbs1_addr_msk),
    .match (match1)
  );

  assign sel0 = match0;
  assign sel1 = match1 & ~match0;

  assign decode_err = wbm_cyc_i & wbm_stb_i & ~(sel0 | sel1);

  assign wbs0_adr_o = wbm_adr_i;
  assign wbs0_dat_o = wbm_dat_i;
  assign wbs0_we_o  = wbm_we_i;
  assign wbs0_sel_o = wbm_sel_i;

  assign wbs1_adr_o = wbm_adr_i;
  assign wbs1_dat_o = wbm_dat_i;
  assign wbs1_we_o  = wbm_we_i;
  assign wbs1_sel_o = wbm_sel_i;

  assign wbs0_cyc_o = wbm_cyc_i & sel0 & rst;
  assign wbs0_stb_o = wbm_stb_i & sel0 & rst;
  assign wbs1_cyc_o = wbm_cyc_i & sel1 & rst;
  assign wbs1_stb_o = wbm_stb_i & sel1 & rst;

  always_comb begin
    wbm_dat_o = '0;
    unique case (1'b1)
      sel0:    wbm_dat_o = wbs0_dat_i;
      sel1:    wbm_dat_o = wbs1_dat_i;
      default: wbm_dat_o = '0;
    endcase
  end

  assign wbm_ack_o = (wbs0_ack_i | wbs1_ack_i) & rst;
  assign wbm_rty_o = (wbs0_rty_i | wbs1_rty_i) & rst;
  assign wbm_err_o = (wbs0_err_i | wbs1_err_i | decode_err) & rst;

endmodule

// File: tb/tb_wb_addr_mux_2.sv
// Randomized bench for wb_addr_mux_2 against a window-decode model.
module tb_wb_addr_mux_2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic        wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [3:0]  wbm_sel_i;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs0_adr_o, wbs0_dat_i, wbs0_dat_o, wbs0_addr, wbs0_addr_msk;
  logic [31:0] wbs1_adr_o, wbs1_dat_i, wbs1_dat_o, wbs1_addr, wbs1_addr_msk;
  logic        wbs0_we_o, wbs0_stb_o, wbs0_ack_i, wbs0_err_i, wbs0_rty_i, wbs0_cyc_o;
  logic        wbs1_we_o, wbs1_stb_o, wbs1_ack_i, wbs1_err_i, wbs1_rty_i, wbs1_cyc_o;
  logic [3:0]  wbs0_sel_o, wbs1_sel_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_addr_mux_2 dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbm_cyc_i(wbm_cyc_i),
    .wbs0_adr_o(wbs0_adr_o), .wbs0_dat_i(wbs0_dat_i), .wbs0_dat_o(wbs0_dat_o),
    .wbs0_we_o(wbs0_we_o), .wbs0_sel_o(wbs0_sel_o), .wbs0_stb_o(wbs0_stb_o),
    .wbs0_ack_i(wbs0_ack_i), .wbs0_err_i(wbs0_err_i), .wbs0_rty_i(wbs0_rty_i),
    .wbs0_cyc_o(wbs0_cyc_o), .wbs0_addr(wbs0_addr), .wbs0_addr_msk(wbs0_addr_msk),
    .wbs1_adr_o(wbs1_adr_o), .wbs1_dat_i(wbs1_dat_i), .wbs1_dat_o(wbs1_dat_o),
    .wbs1_we_o(wbs1_we_o), .wbs1_sel_o(wbs1_sel_o), .wbs1_stb_o(wbs1_stb_o),
    .wbs1_ack_i(wbs1_ack_i), .wbs1_err_i(wbs1_err_i), .wbs1_rty_i(wbs1_rty_i),
    .wbs1_cyc_o(wbs1_cyc_o), .wbs1_addr(wbs1_addr), .wbs1_addr_msk(wbs1_addr_msk)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: which window owns the address, then what the master sees.
  task automatic check_all(input string tag);
    bit in0, in1, own0, own1, none;
    logic [31:0] e_dat;
    in0  = ((wbm_adr_i ^ wbs0_addr) & wbs0_addr_msk) == 32'd0;
    in1  = ((wbm_adr_i ^ wbs1_addr) & wbs1_addr_msk) == 32'd0;
    own0 = in0;
    own1 = in1 && !in0;
    none = !own0 && !own1;
    e_dat = own0 ? wbs0_dat_i : (own1 ? wbs1_dat_i : 32'd0);
    chk({tag, ".dat"}, wbm_dat_o, e_dat);
    chk({tag, ".cyc0"}, wbs0_cyc_o, rst && wbm_cyc_i && own0);
    chk({tag, ".stb0"}, wbs0_stb_o, rst && wbm_stb_i && own0);
    chk({tag, ".cyc1"}, wbs1_cyc_o, rst && wbm_cyc_i && own1);
    chk({tag, ".stb1"}, wbs1_stb_o, rst && wbm_stb_i && own1);
    chk({tag, ".ack"}, wbm_ack_o, rst && (wbs0_ack_i || wbs1_ack_i));
    chk({tag, ".rty"}, wbm_rty_o, rst && (wbs0_rty_i || wbs1_rty_i));
    chk({tag, ".err"}, wbm_err_o,
        rst && (wbs0_err_i || wbs1_err_i || (wbm_cyc_i && wbm_stb_i && none)));
    chk({tag, ".pass0"}, {wbs0_adr_o, wbs0_dat_o[27:0], wbs0_we_o, wbs0_sel_o[2:0]},
        {wbm_adr_i, wbm_dat_i[27:0], wbm_we_i, wbm_sel_i[2:0]});
    chk({tag, ".pass1"}, {wbs1_adr_o, wbs1_dat_o[27:0], wbs1_we_o, wbs1_sel_o[2:0]},
        {wbm_adr_i, wbm_dat_i[27:0], wbm_we_i, wbm_sel_i[2:0]});
    chk({tag, ".hi"}, {wbs0_dat_o[31:28], wbs0_sel_o[3], wbs1_dat_o[31:28], wbs1_sel_o[3]},
        {wbm_dat_i[31:28], wbm_sel_i[3], wbm_dat_i[31:28], wbm_sel_i[3]});
  endtask

  task automatic idle_bus();
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = 0; wbm_sel_i = '0;
    wbm_stb_i = 0; wbm_cyc_i = 0;
    wbs0_dat_i = '0; wbs0_ack_i = 0; wbs0_err_i = 0; wbs0_rty_i = 0;
    wbs1_dat_i = '0; wbs1_ack_i = 0; wbs1_err_i = 0; wbs1_rty_i = 0;
    wbs0_addr = 32'h0000_0000; wbs0_addr_msk = 32'hFFFF_0000;
    wbs1_addr = 32'h0001_0000; wbs1_addr_msk = 32'hFFFF_0000;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    idle_bus();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbs0_ack_i = 1;
    step(); #1;
    chk("rst.ack", wbm_ack_o, 1'b0);
    chk("rst.err", wbm_err_o, 1'b0);
    chk("rst.cyc0", wbs0_cyc_o, 1'b0);
    check_all("rst");

    rst = 1;
    idle_bus();
    step();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = 32'h0000_0004;
    wbs0_dat_i = 32'h1122_3344; wbs0_ack_i = 1;
    #1;
    chk("rd0.cyc0", wbs0_cyc_o, 1'b1);
    chk("rd0.cyc1", wbs1_cyc_o, 1'b0);
    chk("rd0.dat", wbm_dat_o, 32'h1122_3344);
    chk("rd0.ack", wbm_ack_o, 1'b1);
    check_all("rd0");

    rst = 0; #1;
    chk("midrst.cyc0", wbs0_cyc_o, 1'b0);
    chk("midrst.ack", wbm_ack_o, 1'b0);
    check_all("midrst");
    rst = 1; #1;
    chk("rel.cyc0", wbs0_cyc_o, 1'b1);
    chk("rel.ack", wbm_ack_o, 1'b1);

    step(); idle_bus();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = 32'h0001_0008;
    wbm_we_i = 1; wbm_sel_i = 4'hF; wbm_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("wr1.cyc1", wbs1_cyc_o, 1'b1);
    chk("wr1.dat1", wbs1_dat_o, 32'hDEAD_BEEF);
    chk("wr1.cyc0", wbs0_cyc_o, 1'b0);
    wbs1_ack_i = 1; #1;
    chk("wr1.ack", wbm_ack_o, 1'b1);
    wbs1_err_i = 1; #1;
    chk("wr1.err", wbm_err_o, 1'b1);
    check_all("wr1");

    step(); idle_bus();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = 32'h0002_0000;
    wbs0_dat_i = 32'hAAAA_5555; wbs1_dat_i = 32'h5555_AAAA;
    #1;
    chk("unmap.err", wbm_err_o, 1'b1);
    chk("unmap.dat", wbm_dat_o, 32'd0);
    chk("unmap.stb", {wbs0_stb_o, wbs1_stb_o}, 2'b00);
    check_all("unmap");

    step(); idle_bus();
    wbs0_addr_msk = '0; wbs1_addr_msk = '0;
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = 32'h1234_5678;
    wbs0_rty_i = 1;
    #1;
    chk("ovl.sel", {wbs0_cyc_o, wbs1_cyc_o}, 2'b10);
    chk("ovl.rty", wbm_rty_o, 1'b1);
    check_all("ovl");

    for (int i = 0; i < 400; i++) begin
      step();
      rst = ($urandom_range(0, 9) != 0);
      wbs0_addr = $urandom; wbs1_addr = $urandom;
      wbs0_addr_msk = 32'hFFFF_FFFF << $urandom_range(0, 32);
      wbs1_addr_msk = 32'hFFFF_FFFF << $urandom_range(0, 32);
      case ($urandom_range(0, 3))
        0: wbm_adr_i = wbs0_addr ^ ($urandom & ~wbs0_addr_msk);
        1: wbm_adr_i = wbs1_addr ^ ($urandom & ~wbs1_addr_msk);
        default: wbm_adr_i = $urandom;
      endcase
      wbm_dat_i = $urandom; wbm_we_i = 1'($urandom); wbm_sel_i = 4'($urandom);
      wbm_cyc_i = 1'($urandom); wbm_stb_i = 1'($urandom);
      wbs0_dat_i = $urandom; wbs1_dat_i = $urandom;
      {wbs0_ack_i, wbs0_err_i, wbs0_rty_i} = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      {wbs1_ack_i, wbs1_err_i, wbs1_rty_i} = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      #1;
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
